// File: rtl/tx1_wr_arbiter_if.sv
// Bundle of the requester-side and channel-side signals of the TX1 write
// arbiter. The requesters and the channel model sit on the master side; the
// arbiter owns the slave side.
interface tx1_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int HDR_WIDTH  = 61,
    parameter int DATA_WIDTH = 512
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*HDR_WIDTH-1:0]  req_meta;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [HDR_WIDTH-1:0]          out_meta;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_wen;
    logic                          chan_full;
    logic                          chan_empty;
    logic                          fence_busy;
    logic [ID_W-1:0]               grant_id;
    logic [31:0]                   issued_count;
    logic [15:0]                   fence_count;

    modport master (
        output req_valid, req_meta, req_data, chan_full, chan_empty,
        input  req_ready, out_meta, out_data, out_wen, fence_busy,
               grant_id, issued_count, fence_count
    );

    modport slave (
        input  req_valid, req_meta, req_data, chan_full, chan_empty,
        output req_ready, out_meta, out_data, out_wen, fence_busy,
               grant_id, issued_count, fence_count
    );
endinterface

// File: rtl/tx1_wr_arbiter.sv
// Round-robin merge of NUM_REQ TX1 write requesters onto one in-order write
// channel. A WRFENCE acts as a global barrier: once issued, nobody is granted
// until a minimum wait has elapsed and the channel reports empty.
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif
`ifndef CCI_TX1_WRFENCE
`define CCI_TX1_WRFENCE 4'h5
`endif

module tx1_wr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int HDR_WIDTH      = 61,
    parameter int DATA_WIDTH     = 512,
    parameter int FENCE_MIN_WAIT = 2
) (
    input logic clk,
    input logic rst,
    tx1_wr_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (FENCE_MIN_WAIT > 0) ? $clog2(FENCE_MIN_WAIT + 1) : 1;

    typedef enum logic {
        ARB        = 1'b0,
        FENCE_WAIT = 1'b1
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]      wait_cnt;

    logic [NUM_REQ-1:0]    ready_vec;
    logic [ID_W-1:0]       sel_id;
    logic                  sel_vld;
    logic [HDR_WIDTH-1:0]  sel_meta;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_is_fence;

    // Requester index 'off' positions past 'base', wrapping at NUM_REQ
    // (NUM_REQ need not be a power of two, so a plain add is not enough).
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    // Pick the first valid requester at or after rr_ptr; only while
    // arbitrating and the channel has room.
    always_comb begin
        ready_vec = '0;
        sel_id    = '0;
        sel_vld   = 1'b0;
        if (state == ARB && !bus.chan_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!sel_vld && bus.req_valid[wrap_idx(rr_ptr, k)]) begin
                    sel_vld = 1'b1;
                    sel_id  = wrap_idx(rr_ptr, k);
                end
            end
            if (sel_vld) ready_vec[sel_id] = 1'b1;
        end
    end

    assign bus.req_ready = ready_vec;

    // Steer the granted requester's header/data and classify it.
    always_comb begin
        sel_meta     = bus.req_meta[sel_id*HDR_WIDTH +: HDR_WIDTH];
        sel_data     = bus.req_data[sel_id*DATA_WIDTH +: DATA_WIDTH];
        sel_is_fence = (sel_meta[`TX_META_TYPERANGE] == `CCI_TX1_WRFENCE);
    end

    // Issue register, round-robin pointer, statistics and fence state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ARB;
            rr_ptr           <= '0;
            wait_cnt         <= '0;
            bus.out_wen      <= 1'b0;
            bus.out_meta     <= '0;
            bus.out_data     <= '0;
            bus.grant_id     <= '0;
            bus.issued_count <= '0;
            bus.fence_count  <= '0;
            bus.fence_busy   <= 1'b0;
        end else begin
            bus.out_wen <= sel_vld;
            if (sel_vld) begin
                bus.out_meta     <= sel_meta;
                bus.out_data     <= sel_data;
                bus.grant_id     <= sel_id;
                rr_ptr           <= next_ptr(sel_id);
                bus.issued_count <= bus.issued_count + 32'd1;
            end
            case (state)
                ARB: begin
                    if (sel_vld && sel_is_fence) begin
                        state           <= FENCE_WAIT;
                        wait_cnt        <= CNT_W'(FENCE_MIN_WAIT);
                        bus.fence_busy  <= 1'b1;
                        bus.fence_count <= bus.fence_count + 16'd1;
                    end
                end
                FENCE_WAIT: begin
                    // The wait covers the channel's empty-flag latency so a
                    // stale 'empty' from before the fence is never trusted.
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (bus.chan_empty) begin
                        state          <= ARB;
                        bus.fence_busy <= 1'b0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule
